// File: rtl/bsg_clz_normalize_iter_if.sv
// rtl/bsg_clz_normalize_iter_if.sv - operand/result handshake bundle for the iterative CLZ normalizer
interface bsg_clz_normalize_iter_if #(
    parameter int width_p = 16,
    parameter int cnt_w   = $clog2(width_p + 1)
) ();
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               trailing_i;
    logic               v_o;
    logic               yumi_i;
    logic [cnt_w-1:0]   num_zero_o;
    logic [width_p-1:0] norm_o;
    logic               zero_o;

    modport master (
        output v_i, data_i, trailing_i, yumi_i,
        input  ready_o, v_o, num_zero_o, norm_o, zero_o
    );

    modport slave (
        input  v_i, data_i, trailing_i, yumi_i,
        output ready_o, v_o, num_zero_o, norm_o, zero_o
    );
endinterface

// File: rtl/bsg_clz_normalize_iter.sv
// rtl/bsg_clz_normalize_iter.sv - chunked MSB-first leading/trailing zero counter and normalizer
module bsg_clz_normalize_iter #(
    parameter int width_p = 16,
    parameter int chunk_p = 4,
    localparam int cnt_w  = $clog2(width_p + 1)
) (
    input logic clk_i,
    input logic reset_i,
    bsg_clz_normalize_iter_if.slave io
);
    localparam int n_chunks_lp = width_p / chunk_p;
    localparam int idx_w_lp    = (n_chunks_lp > 1) ? $clog2(n_chunks_lp) : 1;

    if (width_p < 2 || chunk_p < 1 || chunk_p > width_p || (width_p % chunk_p) != 0) begin : g_bad_params
        $error("bsg_clz_normalize_iter: illegal width_p/chunk_p combination");
    end

    typedef enum logic [1:0] {IDLE_S, BUSY_S, DONE_S} state_e;

    state_e              state_q, state_d;
    logic [width_p-1:0]  sr_q, sr_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [idx_w_lp-1:0] idx_q, idx_d;
    logic                mode_q, mode_d;
    logic                zero_q, zero_d;

    logic [chunk_p-1:0]  chunk;
    logic [cnt_w-1:0]    lz;
    logic                found;

    function automatic logic [width_p-1:0] bit_rev(input logic [width_p-1:0] x);
        logic [width_p-1:0] r;
        for (int i = 0; i < width_p; i++) begin
            r[i] = x[width_p-1-i];
        end
        return r;
    endfunction

    // Trailing mode works on the bit-reversed operand so one MSB-first scanner serves both modes.
    always_comb begin
        chunk = sr_q[width_p-1 -: chunk_p];
        lz    = '0;
        found = 1'b0;
        for (int i = chunk_p - 1; i >= 0; i--) begin
            if (!found) begin
                if (chunk[i]) begin
                    found = 1'b1;
                end else begin
                    lz = lz + cnt_w'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE_S: begin
                if (io.v_i) begin
                    sr_d    = io.trailing_i ? bit_rev(io.data_i) : io.data_i;
                    mode_d  = io.trailing_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                    zero_d  = 1'b0;
                    state_d = BUSY_S;
                end
            end
            BUSY_S: begin
                if (chunk != '0) begin
                    cnt_d   = cnt_q + lz;
                    sr_d    = sr_q << lz;
                    zero_d  = 1'b0;
                    state_d = DONE_S;
                end else begin
                    cnt_d = cnt_q + cnt_w'(chunk_p);
                    sr_d  = sr_q << chunk_p;
                    idx_d = idx_q + idx_w_lp'(1);
                    if (idx_q == idx_w_lp'(n_chunks_lp - 1)) begin
                        cnt_d   = cnt_w'(width_p);
                        sr_d    = '0;
                        zero_d  = 1'b1;
                        state_d = DONE_S;
                    end
                end
            end
            DONE_S: begin
                if (io.yumi_i) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE_S;
            sr_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            zero_q  <= zero_d;
        end
    end

    assign io.ready_o    = (state_q == IDLE_S);
    assign io.v_o        = (state_q == DONE_S);
    assign io.num_zero_o = cnt_q;
    assign io.norm_o     = mode_q ? bit_rev(sr_q) : sr_q;
    assign io.zero_o     = zero_q;

    a_yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        io.yumi_i |-> (state_q == DONE_S));
endmodule

// File: tb/tb_bsg_clz_normalize_iter.sv
// tb/tb_bsg_clz_normalize_iter.sv - scoreboard bench for bsg_clz_normalize_iter (16-bit, 4-bit chunks)
module tb_bsg_clz_normalize_iter;
    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    bsg_clz_normalize_iter_if #(.width_p(16)) io ();

    bsg_clz_normalize_iter #(.width_p(16), .chunk_p(4)) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .io     (io.slave)
    );

    typedef struct {
        logic [4:0]  cnt;
        logic [15:0] norm;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result and checks it on every cycle v_o is held.
    always @(negedge clk) begin
        if (reset_i) begin
            prev_v = 1'b0;
        end else begin
            if (io.v_o) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                        cur = '{cnt: io.num_zero_o, norm: io.norm_o, zero: io.zero_o, cyc: 0};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("latency_cycle", cyc - acc_cyc + 1, cur.cyc);
                    end
                end
                chk("num_zero", int'(io.num_zero_o), int'(cur.cnt));
                chk("norm", int'(io.norm_o), int'(cur.norm));
                chk("zero", int'(io.zero_o), int'(cur.zero));
            end
            prev_v = io.v_o;
        end
    end

    task automatic wait_ready();
        int to = 0;
        while (!io.ready_o && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [15:0] d, input logic tr, input logic [4:0] ec,
                          input logic [15:0] en, input logic ez, input int ecyc, input int hold);
        int to;
        exp_t e;
        @(negedge clk);
        wait_ready();
        e = '{cnt: ec, norm: en, zero: ez, cyc: ecyc};
        exp_q.push_back(e);
        io.v_i = 1'b1;
        io.data_i = d;
        io.trailing_i = tr;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        io.v_i = 1'b0;
        io.data_i = '0;
        io.trailing_i = 1'b0;
        to = 0;
        @(negedge clk);
        while (!io.v_o && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk("valid_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            chk("ready_low_in_done", int'(io.ready_o), 0);
            io.v_i = i[0];
            io.data_i = 16'hFFFF;
            @(negedge clk);
        end
        io.v_i = 1'b0;
        io.data_i = '0;
        if (hold > 0) chk("valid_held", int'(io.v_o), 1);
        io.yumi_i = 1'b1;
        @(posedge clk);
        #1;
        io.yumi_i = 1'b0;
        @(negedge clk);
        chk("ready_after_yumi", int'(io.ready_o), 1);
        chk("valid_after_yumi", int'(io.v_o), 0);
    endtask

    initial begin
        reset_i = 1'b1;
        io.v_i = 1'b0;
        io.data_i = '0;
        io.trailing_i = 1'b0;
        io.yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(io.ready_o), 1);
        chk("rst_valid", int'(io.v_o), 0);
        chk("rst_num_zero", int'(io.num_zero_o), 0);
        chk("rst_norm", int'(io.norm_o), 0);
        chk("rst_zero", int'(io.zero_o), 0);
        reset_i = 1'b0;

        //      data      tr    cnt  norm      zero cyc hold
        run_op(16'h8000, 1'b0, 5'd0,  16'h8000, 1'b0, 2, 0);
        run_op(16'h0F00, 1'b0, 5'd4,  16'hF000, 1'b0, 3, 0);
        run_op(16'h0001, 1'b0, 5'd15, 16'h8000, 1'b0, 5, 0);
        run_op(16'h0000, 1'b0, 5'd16, 16'h0000, 1'b1, 5, 0);
        run_op(16'h0050, 1'b1, 5'd4,  16'h0005, 1'b0, 3, 0);
        run_op(16'h8000, 1'b1, 5'd15, 16'h0001, 1'b0, 5, 0);
        run_op(16'h1234, 1'b0, 5'd3,  16'h91A0, 1'b0, 2, 0);
        run_op(16'h00F0, 1'b0, 5'd8,  16'hF000, 1'b0, 4, 0);
        run_op(16'h0000, 1'b1, 5'd16, 16'h0000, 1'b1, 5, 0);
        run_op(16'h0F00, 1'b0, 5'd4,  16'hF000, 1'b0, 3, 5);

        // Abort 0x0001 with reset during its second BUSY cycle.
        @(negedge clk);
        wait_ready();
        io.v_i = 1'b1;
        io.data_i = 16'h0001;
        @(posedge clk);
        #1;
        io.v_i = 1'b0;
        io.data_i = '0;
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(io.ready_o), 1);
        chk("abort_valid", int'(io.v_o), 0);
        chk("abort_num_zero", int'(io.num_zero_o), 0);
        chk("abort_norm", int'(io.norm_o), 0);
        chk("abort_zero", int'(io.zero_o), 0);

        run_op(16'h4000, 1'b0, 5'd1, 16'h8000, 1'b0, 2, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
